// File: rtl/csa_acc_pkg.sv
// Shared constants, state encoding and chunk helper for the CSA accumulator sequencer.
package csa_acc_pkg;

  localparam int unsigned W     = 94;
  localparam int unsigned CHUNK = 32;
  localparam int unsigned NCH   = (W + CHUNK - 1) / CHUNK;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW1   = CHUNK + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Width of chunk j; only the top chunk may be narrower than CHUNK.
  function automatic int unsigned chunk_w(input int unsigned j);
    return (j == NCH - 1) ? (W - (NCH - 1) * CHUNK) : CHUNK;
  endfunction

endpackage

// File: rtl/csa_94.sv
// 94-bit 3:2 carry-save adder; the carry word is pre-shifted and its top bit dropped.
module csa_94
  import csa_acc_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_acc_seq.sv
// Multi-operand accumulator: streams operands through one CSA into a redundant
// sum/carry pair, then resolves it to binary one chunk per cycle.
module csa_acc_seq
  import csa_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             abort,
  input  logic             term_valid,
  input  logic [W-1:0]     term_data,
  output logic             term_ready,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [W-1:0]     result,
  output logic             busy
);

  state_t           state;
  logic [W-1:0]     sum_r;
  logic [W-1:0]     carry_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nterms;
  logic [IDX_W-1:0] idx;
  logic             cy;

  logic [W-1:0]     csa_s;
  logic [W-1:0]     csa_c;
  logic             hs;
  logic [CNT_W-1:0] cnt_nxt;

  int unsigned      shift;
  logic [CHUNK-1:0] s_ch;
  logic [CHUNK-1:0] c_ch;
  logic [CHUNK:0]   ch_sum;
  logic [W-1:0]     mask;
  logic [W-1:0]     merged;

  csa_94 u_csa (
    .x (sum_r),
    .y (carry_r),
    .z (term_data),
    .s (csa_s),
    .c (csa_c)
  );

  assign term_ready = (state == ACCUM) && !abort;
  assign busy       = (state != IDLE);
  assign hs         = term_valid && term_ready;
  assign cnt_nxt    = cnt + CNT_W'(1);

  // Carry-propagate slice for the current chunk, merged into the held result.
  always_comb begin
    shift  = 32'(idx) * CHUNK;
    s_ch   = CHUNK'(sum_r >> shift);
    c_ch   = CHUNK'(carry_r >> shift);
    ch_sum = CW1'(s_ch) + CW1'(c_ch) + CW1'(cy);
    mask   = ((W'(1) << chunk_w(32'(idx))) - W'(1)) << shift;
    merged = (result & ~mask) | ((W'(ch_sum[CHUNK-1:0]) << shift) & mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sum_r        <= '0;
      carry_r      <= '0;
      cnt          <= '0;
      nterms       <= '0;
      idx          <= '0;
      cy           <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Abort wins over any coincident handshake; accumulators are discarded.
      state        <= IDLE;
      sum_r        <= '0;
      carry_r      <= '0;
      cnt          <= '0;
      idx          <= '0;
      cy           <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            nterms  <= num_terms;
            sum_r   <= '0;
            carry_r <= '0;
            cnt     <= '0;
            idx     <= '0;
            cy      <= 1'b0;
            state   <= (num_terms == '0) ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (hs) begin
            sum_r   <= csa_s;
            carry_r <= csa_c;
            cnt     <= cnt_nxt;
            if (cnt_nxt == nterms) begin
              idx   <= '0;
              cy    <= 1'b0;
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          result <= merged;
          cy     <= ch_sum[CHUNK];
          if (idx == IDX_W'(NCH - 1)) begin
            idx          <= '0;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_acc_seq.sv
// Scoreboard bench for csa_acc_seq: expected sums are queued at start and checked on result handshake.
module tb_csa_acc_seq;
  import csa_acc_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             abort = 1'b0;
  logic             term_valid = 1'b0;
  logic [W-1:0]     term_data = '0;
  logic             term_ready;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic [W-1:0]     result;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] terms[8];
  int           nt;
  logic [W-1:0] sb_e;

  csa_acc_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_terms    (num_terms),
    .abort        (abort),
    .term_valid   (term_valid),
    .term_data    (term_data),
    .term_ready   (term_ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: a result handshake at the next rising edge pops one expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected result=%h", result);
      end else begin
        sb_e = exp_q.pop_front();
        if (result !== sb_e) begin
          errors++;
          $display("FAIL scoreboard_result got=%h exp=%h", result, sb_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    num_terms = CNT_W'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic feed_all();
    for (int i = 0; i < nt; i++) begin
      int g;
      g = 0;
      term_valid = 1'b1;
      term_data  = terms[i];
      while (!term_ready && g < 20) begin
        tick();
        g++;
      end
      tick();
    end
    term_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] expv, input string name);
    int lat;
    do_start(nt);
    exp_q.push_back(expv);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy got=%b exp=1", name, busy);
    end
    feed_all();
    wait_valid(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL %s_latency got=%0d exp=3", name, lat);
    end
    take_result();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release got valid=%b busy=%b exp 0 0", name, result_valid, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (term_ready !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b busy=%b result=%h exp 0", term_ready, result_valid, busy, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    nt = 3;
    terms[0] = W'(5);
    terms[1] = W'(7);
    terms[2] = W'(9);
    run_op(W'(21), "basic");
  endtask

  task automatic test_chunk_carry();
    nt = 2;
    terms[0] = W'(64'hFFFF_FFFF);
    terms[1] = W'(1);
    run_op(W'(64'h1_0000_0000), "chunk_carry");
  endtask

  task automatic test_wrap();
    nt = 2;
    terms[0] = '1;
    terms[1] = W'(1);
    run_op('0, "wrap");
  endtask

  task automatic test_zero_terms();
    nt = 0;
    run_op('0, "zero_terms");
  endtask

  task automatic test_gaps();
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int acc;
    int k;
    int lat;
    logic [W-1:0] expv;
    expv = '0;
    for (int i = 0; i < 4; i++) begin
      terms[i] = W'({$urandom, $urandom, $urandom});
      expv     = expv + terms[i];
    end
    do_start(4);
    exp_q.push_back(expv);
    acc = 0;
    k   = 0;
    for (int c = 0; c < 7; c++) begin
      term_valid = (pat[c] != 0);
      term_data  = (pat[c] != 0) ? terms[k] : W'({$urandom, $urandom, $urandom});
      if (term_valid && term_ready) begin
        acc++;
        k++;
      end
      tick();
    end
    term_valid = 1'b0;
    checks++;
    if (acc != 4) begin
      errors++;
      $display("FAIL gaps_accepts got=%0d exp=4", acc);
    end
    wait_valid(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL gaps_latency got=%0d exp=3", lat);
    end
    // Stall the consumer and poke start; the held result must not move.
    num_terms = '0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      checks++;
      if (result_valid !== 1'b1 || result !== expv) begin
        errors++;
        $display("FAIL gaps_hold cyc=%0d got valid=%b result=%h exp 1 %h", c, result_valid, result, expv);
      end
    end
    start = 1'b0;
    take_result();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_release got=%b exp=0", result_valid);
    end
  endtask

  task automatic test_abort();
    int seen;
    nt = 2;
    terms[0] = W'(100);
    terms[1] = W'(200);
    do_start(4);
    feed_all();
    abort      = 1'b1;
    term_valid = 1'b1;
    term_data  = W'(300);
    #1;
    checks++;
    if (term_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready got=%b exp=0", term_ready);
    end
    tick();
    abort      = 1'b0;
    term_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b valid=%b exp 0 0", busy, result_valid);
    end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (result_valid === 1'b1) seen++;
      tick();
    end
    abort = 1'b1;
    start = 1'b1;
    num_terms = CNT_W'(1);
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got valid_cycles=%0d busy=%b exp 0 0", seen, busy);
    end
    nt = 2;
    terms[0] = W'(1);
    terms[1] = W'(1);
    run_op(W'(2), "after_abort");
  endtask

  task automatic test_reset_mid();
    nt = 2;
    terms[0] = W'(5);
    terms[1] = W'(7);
    do_start(2);
    feed_all();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (term_ready !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid got ready=%b valid=%b busy=%b result=%h exp 0", term_ready, result_valid, busy, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    nt = 1;
    terms[0] = W'(42);
    run_op(W'(42), "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chunk_carry();
    test_wrap();
    test_zero_terms();
    test_gaps();
    test_abort();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_acc_seq.md
Name: csa_acc_seq

Overview:
- Multi-operand accumulator sequencer built around the team's 94-bit carry-save adder (csa_94).
- Streams N operands, one per handshake, into a redundant sum/carry register pair through a single shared CSA.
- Resolves the redundant pair to binary with a chunked carry-propagate pass.
- Sits between the partial-product generator and the reduction stage of the 89x89 multiplier path.

Parameters:
- W, 94, datapath width; fixed to match csa_94.
- CHUNK, 32, bits resolved per cycle in the carry-propagate pass; NCH = ceil(W/CHUNK), which is 3 at the defaults.
- CNT_W, 8, width of the operand count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin an operation; sampled only in IDLE.
- num_terms  in  CNT_W  operand count, captured on the start edge.
- abort  in  1  synchronous cancel of the current operation.
- term_valid  in  1  operand valid.
- term_data  in  W  operand value.
- term_ready  out  1  operand accept.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result  out  W  binary sum mod 2^W.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; sum_r, carry_r, result, cnt and the chunk index are cleared to 0. term_ready=0, result_valid=0, busy=0. This applies in any state, including mid-ACCUM and mid-RESOLVE. No partial result survives reset.
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - start=1 and abort=0: capture num_terms; clear sum_r, carry_r and cnt.
  - Next state is ACCUM, or RESOLVE when num_terms==0.
- ACCUM:
  - term_ready = ~abort.
  - On a handshake (term_valid & term_ready): {carry_r, sum_r} <= csa_94(x=sum_r, y=carry_r, z=term_data); cnt++.
  - The csa_94 top carry is dropped, and c[0] is 0 by construction, so arithmetic is mod 2^W.
  - Throughput is 1 operand per cycle. Gaps in term_valid are allowed and leave state unchanged.
  - On the handshake where cnt+1 == num_terms, go to RESOLVE.
- RESOLVE:
  - term_ready=0.
  - Chunk j (0..NCH-1), one per cycle: result[j*CHUNK +: CHUNK] <= sum_r chunk + carry_r chunk + cin.
  - cin is 0 for j=0; otherwise it is the registered carry-out of chunk j-1.
  - The last chunk is W-(NCH-1)*CHUNK bits wide (30 at defaults). Its carry-out is discarded.
  - After chunk NCH-1, go to DONE.
- DONE:
  - result_valid=1; result is held stable.
  - When result_valid & result_ready: go to IDLE, and result_valid drops on that edge.
  - result keeps its value until the next start edge.
- Latency:
  - result_valid rises NCH edges after the edge accepting the last operand.
  - When num_terms==0, it rises NCH edges after the start edge, with result=0.
- start outside IDLE is ignored.
- abort priority:
  - abort=1 in ACCUM, RESOLVE or DONE: go to IDLE next edge and clear the accumulators. result_valid=0.
  - abort beats a coincident term handshake; term_ready is already low in that cycle.
  - abort beats a coincident start in IDLE, where the start is ignored.
  - abort in IDLE has no effect.
- busy is combinational from the state.

Decomposition:
- Package csa_acc_pkg:
  - state enum (IDLE/ACCUM/RESOLVE/DONE);
  - W, CHUNK and NCH constants;
  - chunk-width helper function.
- One sub-module, the existing csa_94, instantiated once in ACCUM with x=sum_r, y=carry_r, z=term_data.
- The chunked adder and the FSM stay inline.

Test Plan:
- num_terms=3, terms 5, 7, 9 back-to-back → result=21; result_valid 3 edges after the 9 is accepted; busy high throughout.
- num_terms=2, terms 0xFFFFFFFF and 1 → result=0x1_0000_0000, exercising the chunk0→chunk1 carry.
- num_terms=2, terms 2^94-1 and 1 → result=0 (wrap). Also num_terms=0 → result=0, result_valid 3 edges after start.
- num_terms=4 with term_valid toggling 1,0,0,1,1,0,1 → exactly 4 accepts and the correct sum. Hold result_ready=0 for 5 cycles → result_valid and result stable. Assert start during DONE → ignored.
- abort after 2 of 4 terms → IDLE next edge with no result_valid. A following op (1 + 1) → result=2, with no residue from the aborted op.
- Drop rst_n during RESOLVE chunk 1 → term_ready, result_valid, busy and result are 0 immediately, without a clock. After release, a 1-term op with term 42 → result=42.
